// File: rtl/cpuclk_monitor.sv
// cpuclk_monitor: samples divided CPUCLK in the CLK domain, emits edge strobes,
// measures half-period, and reports lock/stall against the expected division.
module cpuclk_monitor #(
    parameter int EXP_HALF   = 7,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 32,
    parameter int CNT_W      = 6
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             CPUCLK,
    input  logic             enable,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             locked,
    output logic             stalled,
    output logic [7:0]       err_count
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    typedef enum logic [2:0] {IDLE, ACQUIRE, TRACK, LOCKED, STALL} state_t;
    state_t state, state_n;
    logic s1, s2, s3, e, rise;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0] good, good_n;
    logic in_tol, load, bad;
    assign in_tol  = cnt >= CNT_W'(EXP_HALF - TOL) && cnt <= CNT_W'(EXP_HALF + TOL);
    assign locked  = state == LOCKED;
    assign stalled = state == STALL;
    always_comb begin
        state_n = state;
        good_n  = good;
        load    = 1'b0;
        bad     = 1'b0;
        case (state)
            IDLE:    state_n = ACQUIRE;
            ACQUIRE: if (e) begin
                state_n = TRACK;
                good_n  = '0;
            end
            TRACK: if (e) begin
                load = 1'b1;
                if (in_tol) begin
                    good_n = good + 1'b1;
                    if (good_n == GW'(LOCK_COUNT)) state_n = LOCKED;
                end else begin
                    good_n = '0;
                    bad    = 1'b1;
                end
            end
            LOCKED: if (e) begin
                load = 1'b1;
                if (!in_tol) begin
                    state_n = TRACK;
                    good_n  = '0;
                    bad     = 1'b1;
                end
            end
            STALL: if (e) begin
                state_n = TRACK;
                good_n  = '0;
            end
            default: state_n = IDLE;
        endcase
        // an edge arriving on the timeout cycle wins over the stall
        if (state != IDLE && state != STALL && !e && cnt == CNT_W'(TIMEOUT)) state_n = STALL;
        if (!enable) begin
            state_n = IDLE;
            good_n  = '0;
            load    = 1'b0;
            bad     = 1'b0;
        end
    end
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            {s1, s2, s3, e, rise} <= '0;
            state       <= IDLE;
            good        <= '0;
            cnt         <= '0;
            half_period <= '0;
            err_count   <= '0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
        end else begin
            s1          <= CPUCLK;
            s2          <= s1;
            s3          <= s2;
            e           <= s2 ^ s3;
            rise        <= s2 & ~s3;
            state       <= state_n;
            good        <= good_n;
            cnt         <= (!enable || state == IDLE) ? '0 : e ? CNT_W'(1) : (&cnt) ? cnt : cnt + 1'b1;
            half_period <= load ? cnt : half_period;
            err_count   <= (bad && !(&err_count)) ? err_count + 1'b1 : err_count;
            rise_pulse  <= enable && state != IDLE && e && rise;
            fall_pulse  <= enable && state != IDLE && e && !rise;
        end
    end
endmodule
